// File: rtl/char_lcd_pkg.sv
// rtl/char_lcd_pkg.sv - shared FSM encoding, LCD command bytes and row base offsets
package char_lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_FUNC,
        INIT_DISP,
        INIT_ENTRY,
        INIT_CLR,
        CLR_WAIT,
        SET_ADDR,
        WR_CHAR
    } lcd_state_t;

    // 8-bit bus, two-line mode, 5x8 font
    localparam logic [7:0] CMD_FUNC  = 8'h38;
    // display on, cursor off, blink off
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    // auto-increment address, no display shift
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    // set DDRAM address; OR with the row base offset
    localparam logic [7:0] CMD_ADDR  = 8'h80;

    // DDRAM start address of each row; rows 2/3 continue rows 0/1 after COLS chars
    function automatic logic [7:0] row_base(input logic [1:0] row, input int cols);
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(cols);
            default: row_base = 8'(cols) + 8'h40;
        endcase
    endfunction

endpackage

// File: rtl/char_lcd_tick.sv
// rtl/char_lcd_tick.sv - divides the system clock into a one-clock LCD tick enable
module char_lcd_tick #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // free-running modulo-CLK_DIV counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/char_lcd_buf_ctrl.sv
// rtl/char_lcd_buf_ctrl.sv - character buffer with HD44780-style init and continuous refresh
module char_lcd_buf_ctrl
    import char_lcd_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int PWR_TICKS = 16000,
    parameter int CLR_TICKS = 2000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]    wr_addr,
    input  logic [7:0]                      wr_data,
    output logic                            lcd_e,
    output logic                            lcd_rs,
    output logic                            lcd_rw,
    output logic [7:0]                      lcd_db,
    output logic                            init_done,
    output logic                            frame_done
);

    localparam int AW   = $clog2(ROWS * COLS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(COLS);
    localparam int MAXW = (PWR_TICKS > CLR_TICKS) ? PWR_TICKS : CLR_TICKS;
    localparam int WW   = $clog2(MAXW + 1);

    logic            tick;
    logic [7:0]      mem [ROWS*COLS];

    lcd_state_t      state, state_n;
    logic [1:0]      phase, phase_n;
    logic [WW-1:0]   wait_cnt, wait_n;
    logic [RW-1:0]   row, row_n;
    logic [CW-1:0]   col, col_n;
    logic            e_n, rs_n, done_n, frame_n;
    logic [7:0]      db_n;
    logic            xfer_rs;
    logic [7:0]      xfer_byte;
    logic [AW-1:0]   rd_idx;

    assign lcd_rw = 1'b0;
    assign rd_idx = AW'(int'(row) * COLS + int'(col));

    char_lcd_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // character buffer: host writes land on the next edge, out-of-range indices dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS * COLS; i++) begin
                mem[i] <= 8'h20;
            end
        end else if (wr_en && (int'(wr_addr) < ROWS * COLS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // state, counters and registered LCD pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PWR_WAIT;
            phase      <= 2'd0;
            wait_cnt   <= '0;
            row        <= '0;
            col        <= '0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            wait_cnt   <= wait_n;
            row        <= row_n;
            col        <= col_n;
            lcd_e      <= e_n;
            lcd_rs     <= rs_n;
            lcd_db     <= db_n;
            init_done  <= done_n;
            frame_done <= frame_n;
        end
    end

    // next-state logic; each byte is a 4-tick transfer (setup, e high x2, e low)
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        wait_n    = wait_cnt;
        row_n     = row;
        col_n     = col;
        e_n       = lcd_e;
        rs_n      = lcd_rs;
        db_n      = lcd_db;
        done_n    = init_done;
        frame_n   = 1'b0;
        xfer_rs   = 1'b0;
        xfer_byte = 8'h00;

        case (state)
            INIT_FUNC:  xfer_byte = CMD_FUNC;
            INIT_DISP:  xfer_byte = CMD_DISP;
            INIT_ENTRY: xfer_byte = CMD_ENTRY;
            INIT_CLR:   xfer_byte = CMD_CLR;
            SET_ADDR:   xfer_byte = CMD_ADDR | row_base(2'(row), COLS);
            WR_CHAR: begin
                xfer_rs   = 1'b1;
                xfer_byte = mem[rd_idx];
            end
            default: ;
        endcase

        if (tick) begin
            case (state)
                PWR_WAIT: begin
                    if (wait_cnt == WW'(PWR_TICKS - 1)) begin
                        wait_n  = '0;
                        state_n = INIT_FUNC;
                    end else begin
                        wait_n = wait_cnt + 1'b1;
                    end
                end
                CLR_WAIT: begin
                    if (wait_cnt == WW'(CLR_TICKS - 1)) begin
                        wait_n  = '0;
                        done_n  = 1'b1;
                        row_n   = '0;
                        col_n   = '0;
                        state_n = SET_ADDR;
                    end else begin
                        wait_n = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    case (phase)
                        2'd0: begin
                            rs_n = xfer_rs;
                            db_n = xfer_byte;
                            e_n  = 1'b0;
                        end
                        2'd1:    e_n = 1'b1;
                        2'd2:    e_n = 1'b1;
                        default: e_n = 1'b0;
                    endcase
                    phase_n = phase + 2'd1;
                    if (phase == 2'd3) begin
                        case (state)
                            INIT_FUNC:  state_n = INIT_DISP;
                            INIT_DISP:  state_n = INIT_ENTRY;
                            INIT_ENTRY: state_n = INIT_CLR;
                            INIT_CLR:   state_n = CLR_WAIT;
                            SET_ADDR: begin
                                col_n   = '0;
                                state_n = WR_CHAR;
                            end
                            WR_CHAR: begin
                                if (col == CW'(COLS - 1)) begin
                                    col_n   = '0;
                                    state_n = SET_ADDR;
                                    if (row == RW'(ROWS - 1)) begin
                                        row_n   = '0;
                                        frame_n = 1'b1;
                                    end else begin
                                        row_n = row + 1'b1;
                                    end
                                end else begin
                                    col_n = col + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_lcd_buf_ctrl.sv
// tb/tb_char_lcd_buf_ctrl.sv - randomized self-checking bench for char_lcd_buf_ctrl
module tb_char_lcd_buf_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int PWR_TICKS = 10;
    localparam int CLR_TICKS = 5;
    localparam int COLS      = 16;
    localparam int ROWS      = 2;
    localparam int COLS4     = 20;
    localparam int ROWS4     = 4;
    localparam int AW        = $clog2(ROWS * COLS);
    localparam int AW4       = $clog2(ROWS4 * COLS4);

    localparam int E_HIGH_CLKS    = 2 * CLK_DIV;
    localparam int FIRST_E_CLKS   = (PWR_TICKS + 2) * CLK_DIV;
    localparam int INIT_DONE_CLKS = CLR_TICKS * CLK_DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, wr_en, lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data, lcd_db;

    logic           reset4, wr_en4, lcd_e4, lcd_rs4, lcd_rw4, init_done4, frame_done4;
    logic [AW4-1:0] wr_addr4;
    logic [7:0]     wr_data4, lcd_db4;

    char_lcd_buf_ctrl #(
        .CLK_DIV(CLK_DIV), .COLS(COLS), .ROWS(ROWS),
        .PWR_TICKS(PWR_TICKS), .CLR_TICKS(CLR_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
        .init_done(init_done), .frame_done(frame_done)
    );

    char_lcd_buf_ctrl #(
        .CLK_DIV(CLK_DIV), .COLS(COLS4), .ROWS(ROWS4),
        .PWR_TICKS(PWR_TICKS), .CLR_TICKS(CLR_TICKS)
    ) dut4 (
        .clk(clk), .reset(reset4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .lcd_e(lcd_e4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_db(lcd_db4),
        .init_done(init_done4), .frame_done(frame_done4)
    );

    int n_cmp;
    int n_bad;

    logic [7:0] init_cmd [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [7:0] mem  [ROWS*COLS];
    logic [7:0] mem4 [ROWS4*COLS4];
    logic [8:0] cap[$];
    logic [8:0] cap4[$];
    logic [8:0] exp_q[$];
    int         hi_len[$];
    time        t_rise;

    always @(posedge lcd_e) t_rise = $time;
    always @(negedge lcd_e) begin
        cap.push_back({lcd_rs, lcd_db});
        if (!reset) hi_len.push_back(int'(($time - t_rise) / 10));
    end
    always @(negedge lcd_e4) cap4.push_back({lcd_rs4, lcd_db4});

    task automatic build_exp(input bit big);
        int rows, cols, base;
        rows = big ? ROWS4 : ROWS;
        cols = big ? COLS4 : COLS;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            base = (r == 0) ? 0 : (r == 1) ? 'h40 : (r == 2) ? cols : 'h40 + cols;
            exp_q.push_back({1'b0, 8'(8'h80 + base)});
            for (int c = 0; c < cols; c++)
                exp_q.push_back({1'b1, big ? mem4[r*cols+c] : mem[r*cols+c]});
        end
    endtask

    task automatic wait_fd(input bit big, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ((big ? frame_done4 : frame_done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL frame_done_wait: got no pulse in 6000 clocks, want a pulse (big=%0d)", big);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset4 = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
        wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = 8'h00;
        for (int i = 0; i < ROWS4 * COLS4; i++) mem4[i] = 8'h20;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_rw} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pins: got e/rs/rw=%b want 000", {lcd_e, lcd_rs, lcd_rw});
        end
        n_cmp++;
        if (lcd_db !== 8'h00) begin
            n_bad++; $display("FAIL reset_db: got %h want 00", lcd_db);
        end
        n_cmp++;
        if ({init_done, frame_done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got init/frame=%b want 00", {init_done, frame_done});
        end
        n_cmp++;
        if ({lcd_e4, lcd_rw4, lcd_db4, init_done4} !== 11'h0) begin
            n_bad++; $display("FAIL reset_4x20: got e=%b rw=%b db=%h init=%b want zeros", lcd_e4, lcd_rw4, lcd_db4, init_done4);
        end
        reset4 = 1'b0;
    endtask

    task automatic test_init(input bit do_writes);
        int cnt, k;
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = 8'h20;
        cap.delete();
        hi_len.delete();
        reset = 1'b0;
        cnt = 0;
        while (lcd_e !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (do_writes && cnt == 1) begin
                n_cmp++;
                if (init_done !== 1'b0) begin
                    n_bad++; $display("FAIL early_write_init_done: got %b want 0", init_done);
                end
                wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h48; mem[0] = 8'h48;
            end else if (do_writes && cnt == 2) begin
                wr_addr = AW'(17); wr_data = 8'h69; mem[17] = 8'h69;
            end else if (cnt == 3) begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (cnt !== FIRST_E_CLKS) begin
            n_bad++; $display("FAIL first_e_latency: got %0d clocks want %0d", cnt, FIRST_E_CLKS);
        end
        k = 0;
        while (cap.size() < 4 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (cap.size() < 4) begin
            n_bad++; $display("FAIL init_bytes_count: got %0d want 4", cap.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (cap[i] !== {1'b0, init_cmd[i]}) begin
                    n_bad++; $display("FAIL init_byte%0d: got rs/db=%h want %h", i, cap[i], {1'b0, init_cmd[i]});
                end
                n_cmp++;
                if (i >= hi_len.size() || hi_len[i] !== E_HIGH_CLKS) begin
                    n_bad++; $display("FAIL e_high%0d: got %0d clocks want %0d", i, (i < hi_len.size()) ? hi_len[i] : -1, E_HIGH_CLKS);
                end
            end
        end
        k = 0;
        while (init_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== INIT_DONE_CLKS) begin
            n_bad++; $display("FAIL init_done_delay: got %0d clocks want %0d", k, INIT_DONE_CLKS);
        end
        cap.delete();
        hi_len.delete();
    endtask

    task automatic test_default_frame();
        bit ok;
        wait_fd(1'b0, ok);
        build_exp(1'b0);
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL default_frame_len: got %0d want %0d", cap.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (cap[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL default_frame[%0d]: got %h want %h", i, cap[i], exp_q[i]);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++; $display("FAIL frame_done_width: got %b one clock later want 0", frame_done);
        end
        n_cmp++;
        if ({init_done, lcd_rw} !== 2'b10) begin
            n_bad++; $display("FAIL run_flags: got init/rw=%b want 10", {init_done, lcd_rw});
        end
    endtask

    task automatic test_random_writes();
        bit ok;
        int n, a;
        for (int round = 0; round < 3; round++) begin
            cap.delete();
            n = int'($urandom_range(3, 8));
            for (int w = 0; w < n; w++) begin
                a = int'($urandom_range(0, ROWS * COLS - 1));
                wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'($urandom_range(33, 126));
                mem[a] = wr_data;
                @(negedge clk);
            end
            wr_en = 1'b0;
            wait_fd(1'b0, ok);
            cap.delete();
            wait_fd(1'b0, ok);
            build_exp(1'b0);
            n_cmp++;
            if (cap.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL rand_frame_len r%0d: got %0d want %0d", round, cap.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_cmp++;
                    if (cap[i] !== exp_q[i]) begin
                        n_bad++; $display("FAIL rand_frame r%0d [%0d]: got %h want %h", round, i, cap[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int k;
        k = 0;
        while (lcd_e !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (lcd_e !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_find_e: got e=%b want 1", lcd_e);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_db} !== 10'h000) begin
            n_bad++; $display("FAIL mid_reset_async: got e=%b rs=%b db=%h want 0/0/00", lcd_e, lcd_rs, lcd_db);
        end
        n_cmp++;
        if ({init_done, frame_done} !== 2'b00) begin
            n_bad++; $display("FAIL mid_reset_flags: got %b want 00", {init_done, frame_done});
        end
        repeat (2) @(negedge clk);
        test_init(1'b1);
        wait_fd(1'b0, ok);
        build_exp(1'b0);
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL post_reset_frame_len: got %0d want %0d", cap.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (cap[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL post_reset_frame[%0d]: got %h want %h", i, cap[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_4x20();
        bit ok;
        int a;
        wait_fd(1'b1, ok);
        cap4.delete();
        for (int w = 0; w < 8; w++) begin
            wr_en4 = 1'b1;
            if (w % 2 == 0) begin
                a = int'($urandom_range(0, ROWS4 * COLS4 - 1));
                wr_addr4 = AW4'(a); wr_data4 = 8'($urandom_range(33, 126));
                mem4[a] = wr_data4;
            end else begin
                wr_addr4 = AW4'($urandom_range(ROWS4 * COLS4, (1 << AW4) - 1));
                wr_data4 = 8'h41;
            end
            @(negedge clk);
        end
        wr_en4 = 1'b0;
        wait_fd(1'b1, ok);
        cap4.delete();
        wait_fd(1'b1, ok);
        build_exp(1'b1);
        n_cmp++;
        if (cap4.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL frame4x20_len: got %0d want %0d", cap4.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (cap4[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL frame4x20[%0d]: got %h want %h", i, cap4[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_init(1'b0);
        test_default_frame();
        test_random_writes();
        test_mid_reset();
        test_4x20();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
